// File: rtl/riscv_trace_pkg.sv
// Shared types and constants for the riscv retirement trace buffer.
// trace_rec_t follows the default parameter set; other widths use rec_w() with plain packing.
package riscv_trace_pkg;

    localparam int FLG_REG = 0;
    localparam int FLG_MWR = 1;
    localparam int FLG_MRD = 2;

    localparam int TRACE_DATA_W = 32;
    localparam int TRACE_ADDR_W = 9;
    localparam int TRACE_TS_W   = 16;
    localparam int TRACE_REGN_W = 5;

    typedef struct packed {
        logic [TRACE_TS_W-1:0]   ts;
        logic [2:0]              flags;
        logic [TRACE_REGN_W-1:0] reg_num;
        logic [TRACE_ADDR_W-1:0] addr;
        logic [TRACE_DATA_W-1:0] reg_data;
        logic [TRACE_DATA_W-1:0] mem_data;
    } trace_rec_t;

    function automatic int rec_w(input int ts_w, input int addr_w, input int data_w);
        return ts_w + 3 + TRACE_REGN_W + addr_w + 2 * data_w;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Record FIFO with a selectable full policy: drop the incoming record or overwrite the oldest.
// clear_i dominates push/pop. A full FIFO accepts push+pop in the same cycle without loss.
module trace_fifo #(
    parameter int DEPTH     = 16,
    parameter int WIDTH     = 8,
    parameter int OVERWRITE = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       drop_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic full, empty, do_pop, lose, do_write, ovw;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_pop   = pop_i && !empty;
    // A record is lost whenever a push meets a full FIFO that is not also being popped.
    assign lose     = push_i && full && !do_pop;
    assign ovw      = lose && (OVERWRITE != 0);
    assign do_write = push_i && (!lose || ovw);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_write) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop || ovw) rd_ptr_d = rd_ptr_q + PW'(1);
            if (do_write && !do_pop && !ovw) count_d = count_q + CW'(1);
            else if (do_pop && !do_write) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = empty ? '0 : mem_q[rd_ptr_q];
    assign valid_o = !empty;
    assign count_o = count_q;
    assign drop_o  = lose && !clear_i;

endmodule

// File: rtl/riscv_trace_buffer.sv
// Retirement trace capture: timestamps writeback / load / store events into records
// and queues them for a debug host, tracking lost records in overflow and drop_cnt.
module riscv_trace_buffer
    import riscv_trace_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 9,
    parameter int DEPTH     = 16,
    parameter int TS_W      = 16,
    parameter int OVERWRITE = 0
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     trace_en,
    input  logic                                     clear,
    input  logic                                     reg_write_sig,
    input  logic [4:0]                               reg_num,
    input  logic [DATA_W-1:0]                        reg_data,
    input  logic                                     wr,
    input  logic                                     rd,
    input  logic [ADDR_W-1:0]                        addr,
    input  logic [DATA_W-1:0]                        wr_data,
    input  logic [DATA_W-1:0]                        rd_data,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [rec_w(TS_W, ADDR_W, DATA_W)-1:0]   out_rec,
    output logic [$clog2(DEPTH):0]                   count,
    output logic                                     overflow,
    output logic [15:0]                              drop_cnt
);

    localparam int REC_W = rec_w(TS_W, ADDR_W, DATA_W);

    logic [TS_W-1:0]   ts_q, ts_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;

    logic              event_w, pop_w, drop_w;
    logic [2:0]        flags;
    logic [4:0]        reg_num_f;
    logic [ADDR_W-1:0] addr_f;
    logic [DATA_W-1:0] reg_data_f, mem_data_f;
    logic [REC_W-1:0]  rec_w_data;

    assign event_w = trace_en && (reg_write_sig || wr || rd);
    assign pop_w   = out_valid && out_ready;

    // Fields not touched by the event are zeroed so records compare cleanly on the host.
    always_comb begin
        flags          = '0;
        flags[FLG_REG] = reg_write_sig;
        flags[FLG_MWR] = wr;
        flags[FLG_MRD] = rd;
        reg_num_f      = reg_write_sig ? reg_num : '0;
        reg_data_f     = reg_write_sig ? reg_data : '0;
        addr_f         = (wr || rd) ? addr : '0;
        if (wr)      mem_data_f = wr_data;
        else if (rd) mem_data_f = rd_data;
        else         mem_data_f = '0;
    end

    assign rec_w_data = {ts_q, flags, reg_num_f, addr_f, reg_data_f, mem_data_f};

    trace_fifo #(
        .DEPTH     (DEPTH),
        .WIDTH     (REC_W),
        .OVERWRITE (OVERWRITE)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear_i (clear),
        .push_i  (event_w),
        .wdata_i (rec_w_data),
        .pop_i   (pop_w),
        .rdata_o (out_rec),
        .valid_o (out_valid),
        .count_o (count),
        .drop_o  (drop_w)
    );

    always_comb begin
        ts_d       = ts_q + TS_W'(1);
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clear) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else if (drop_w) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q       <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            ts_q       <= ts_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Bench for riscv_trace_buffer: a drop-policy and an overwrite-policy instance (DEPTH=4)
// share one stimulus stream and are checked every cycle against a queue model.
module tb_riscv_trace_buffer;
  import riscv_trace_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        trace_en, clear, reg_write_sig, wr, rd, out_ready;
  logic [4:0]  reg_num;
  logic [31:0] reg_data, wr_data, rd_data;
  logic [8:0]  addr;

  logic        out_valid [2];
  trace_rec_t  out_rec   [2];
  logic [2:0]  count     [2];
  logic        overflow  [2];
  logic [15:0] drop_cnt  [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  riscv_trace_buffer #(.DEPTH(DEPTH), .OVERWRITE(0)) u_drop (
    .clk(clk), .reset(reset), .trace_en(trace_en), .clear(clear),
    .reg_write_sig(reg_write_sig), .reg_num(reg_num), .reg_data(reg_data),
    .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_rec(out_rec[0]),
    .count(count[0]), .overflow(overflow[0]), .drop_cnt(drop_cnt[0])
  );

  riscv_trace_buffer #(.DEPTH(DEPTH), .OVERWRITE(1)) u_ovw (
    .clk(clk), .reset(reset), .trace_en(trace_en), .clear(clear),
    .reg_write_sig(reg_write_sig), .reg_num(reg_num), .reg_data(reg_data),
    .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_rec(out_rec[1]),
    .count(count[1]), .overflow(overflow[1]), .drop_cnt(drop_cnt[1])
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: one record queue per policy, ts as a plain cycle counter.
  trace_rec_t  mq [2][$];
  logic [15:0] m_drop [2];
  logic        m_ovf  [2];
  logic [15:0] ts_m;
  logic        m_ev;
  trace_rec_t  m_rec;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int m = 0; m < 2; m++) begin
        mq[m].delete();
        m_drop[m] = '0;
        m_ovf[m]  = 1'b0;
      end
      ts_m = '0;
    end else begin
      m_ev  = trace_en && (reg_write_sig || wr || rd);
      m_rec = '0;
      m_rec.ts    = ts_m;
      m_rec.flags = {rd, wr, reg_write_sig};
      if (reg_write_sig) begin
        m_rec.reg_num  = reg_num;
        m_rec.reg_data = reg_data;
      end
      if (wr || rd) m_rec.addr = addr;
      m_rec.mem_data = wr ? wr_data : (rd ? rd_data : 32'h0);
      for (int m = 0; m < 2; m++) begin
        if (clear) begin
          mq[m].delete();
          m_drop[m] = '0;
          m_ovf[m]  = 1'b0;
        end else begin
          if (out_ready && mq[m].size() > 0) void'(mq[m].pop_front());
          if (m_ev) begin
            if (mq[m].size() < DEPTH) mq[m].push_back(m_rec);
            else begin
              if (m == 1) begin
                void'(mq[m].pop_front());
                mq[m].push_back(m_rec);
              end
              m_ovf[m] = 1'b1;
              if (m_drop[m] != 16'hFFFF) m_drop[m] = m_drop[m] + 16'd1;
            end
          end
        end
      end
      ts_m = ts_m + 16'd1;
    end
  end

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      trace_rec_t e;
      e = (mq[m].size() != 0) ? mq[m][0] : '0;
      chk($sformatf("m%0d.valid", m), out_valid[m], mq[m].size() != 0);
      chk($sformatf("m%0d.rec", m), out_rec[m], e);
      chk($sformatf("m%0d.count", m), count[m], mq[m].size());
      chk($sformatf("m%0d.overflow", m), overflow[m], m_ovf[m]);
      chk($sformatf("m%0d.drop_cnt", m), drop_cnt[m], m_drop[m]);
    end
  end

  task automatic idle();
    trace_en = 1'b1; clear = 1'b0; reg_write_sig = 1'b0; wr = 1'b0; rd = 1'b0;
    reg_num = '0; reg_data = '0; addr = '0; wr_data = '0; rd_data = '0;
  endtask

  task automatic wait_ts(input int t);
    int n = 0;
    while (ts_m != 16'(t) && n < 70000) begin
      @(negedge clk);
      n++;
    end
    if (ts_m != 16'(t)) chk("wait_ts_timeout", ts_m, 16'(t));
  endtask

  task automatic ev_reg(input int t, input logic [4:0] rn, input logic [31:0] d);
    wait_ts(t);
    reg_write_sig = 1'b1; reg_num = rn; reg_data = d;
    @(negedge clk);
    idle();
  endtask

  task automatic do_clear(input int t);
    wait_ts(t);
    clear = 1'b1;
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    out_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst.valid", out_valid[0], 1'b0);
    chk("rst.count", count[0], 3'd0);
    chk("rst.rec", out_rec[1], 97'd0);
    chk("rst.drop", drop_cnt[1], 16'd0);

    ev_reg(3, 5'd5, 32'hDEAD_BEEF);
    chk("t1.valid", out_valid[0], 1'b1);
    chk("t1.ts", out_rec[0].ts, 16'd3);
    chk("t1.flags", out_rec[0].flags, 3'b001);
    chk("t1.reg_num", out_rec[0].reg_num, 5'd5);
    chk("t1.reg_data", out_rec[0].reg_data, 32'hDEAD_BEEF);

    do_clear(4);
    wr = 1'b1; addr = 9'h004; wr_data = 32'h0000_1234;
    @(negedge clk);
    idle();
    chk("t2.store.flags", out_rec[0].flags, 3'b010);
    chk("t2.store.mem", out_rec[0].mem_data, 32'h0000_1234);
    chk("t2.store.addr", out_rec[0].addr, 9'h004);
    wr = 1'b1; rd = 1'b1; addr = 9'h008; wr_data = 32'h0000_1234; rd_data = 32'h55;
    out_ready = 1'b1;
    @(negedge clk);
    idle();
    out_ready = 1'b0;
    chk("t2.wrrd.flags", out_rec[0].flags, 3'b110);
    chk("t2.wrrd.mem", out_rec[0].mem_data, 32'h0000_1234);
    chk("t2.wrrd.count", count[0], 3'd1);

    do_clear(8);
    for (int t = 10; t <= 15; t++) ev_reg(t, 5'(t), $urandom);
    chk("t3.count", count[0], 3'd4);
    chk("t3.drop", drop_cnt[0], 16'd2);
    chk("t3.ovf", overflow[0], 1'b1);
    chk("t4.count", count[1], 3'd4);
    chk("t4.drop", drop_cnt[1], 16'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t3.drain_ts", out_rec[0].ts, 16'(10 + i));
      chk("t4.drain_ts", out_rec[1].ts, 16'(12 + i));
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("t3.empty", count[0], 3'd0);

    do_clear(30);
    for (int t = 32; t <= 35; t++) ev_reg(t, 5'd1, $urandom);
    wait_ts(36);
    reg_write_sig = 1'b1; reg_num = 5'd2; reg_data = 32'h36;
    out_ready = 1'b1;
    @(negedge clk);
    idle();
    out_ready = 1'b0;
    chk("t5.count0", count[0], 3'd4);
    chk("t5.count1", count[1], 3'd4);
    chk("t5.drop0", drop_cnt[0], 16'd0);
    chk("t5.drop1", drop_cnt[1], 16'd0);
    chk("t5.head", out_rec[0].ts, 16'd33);

    wait_ts(40);
    clear = 1'b1; reg_write_sig = 1'b1; reg_num = 5'd7;
    @(negedge clk);
    idle();
    chk("t6.clr.count", count[0], 3'd0);
    chk("t6.clr.valid", out_valid[1], 1'b0);
    chk("t6.clr.drop", drop_cnt[0], 16'd0);
    ev_reg(45, 5'd9, 32'h45);
    chk("t6.ts_after_clear", out_rec[0].ts, 16'd45);
    chk("t6.count1", count[0], 3'd1);

    for (int t = 47; t <= 52; t++) ev_reg(t, 5'd3, $urandom);
    out_ready = 1'b1;
    @(negedge clk);
    #3 reset = 1'b1;
    #1;
    chk("t6.rst.valid", out_valid[0], 1'b0);
    chk("t6.rst.count", count[1], 3'd0);
    chk("t6.rst.drop", drop_cnt[0], 16'd0);
    chk("t6.rst.ovf", overflow[1], 1'b0);
    chk("t6.rst.rec", out_rec[0], 97'd0);
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    reg_write_sig = 1'b1; reg_num = 5'd1;
    @(negedge clk);
    idle();
    chk("t6.ts_after_reset", out_rec[0].ts, 16'd0);

    for (int i = 0; i < 3000; i++) begin
      trace_en      = ($urandom_range(0, 7) != 0);
      clear         = ($urandom_range(0, 63) == 0);
      reg_write_sig = $urandom_range(0, 1);
      wr            = ($urandom_range(0, 2) == 0);
      rd            = ($urandom_range(0, 2) == 0);
      reg_num       = 5'($urandom);
      reg_data      = $urandom;
      addr          = 9'($urandom);
      wr_data       = $urandom;
      rd_data       = $urandom;
      out_ready     = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      @(negedge clk);
    end
    idle();
    out_ready = 1'b1;
    repeat (8) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
